// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives word addresses into a 1-cycle instruction ROM and
// queues returned words for decode. Optional macro IF_RANGE_CHECK_EN adds the out-of-range fault.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic [ADDR_W-1:0] Address,
    input  logic [31:0]       Instr,
    input  logic              Redirect_Valid,
    input  logic [31:0]       Redirect_Target,
    output logic              IF_Valid,
    input  logic              IF_Ready,
    output logic [31:0]       IF_Instr,
    output logic [31:0]       IF_PC,
    output logic              Fetch_Fault
);
    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
    localparam logic [31:0] PC_RST = RESET_PC & ~32'h3;

    logic [31:0]      r_pc;
    logic [31:0]      r_req_pc;
    logic             r_inflight;
    logic [31:0]      r_q_instr [QDEPTH];
    logic [31:0]      r_q_pc    [QDEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_fault;

    logic             w_pop;
    logic             w_push;
    logic             w_credit;
    logic             w_oor;
    logic             w_try;
    logic             w_issue;
    logic [31:0]      w_pc_nxt;
    logic             w_inflight_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic             w_fault_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == QDEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign Address  = r_pc[ADDR_W+1:2];
    assign IF_Valid = (r_count != '0);
    assign IF_Instr = r_q_instr[r_rd_ptr];
    assign IF_PC    = r_q_pc[r_rd_ptr];
`ifdef IF_RANGE_CHECK_EN
    assign Fetch_Fault = r_fault;
    assign w_oor       = |r_pc[31:ADDR_W+2];
`else
    assign Fetch_Fault = 1'b0;
    assign w_oor       = 1'b0;
`endif

    // Credit counts queued words plus the word in flight, so a return can never overflow the queue.
    always_comb begin
        w_pop          = IF_Valid & IF_Ready & ~Redirect_Valid;
        w_push         = r_inflight & ~Redirect_Valid;
        w_credit       = (32'(r_count) + 32'(r_inflight) - 32'(w_pop)) < QDEPTH;
        w_try          = w_credit & ~Redirect_Valid & ~r_fault;
        w_issue        = w_try & ~w_oor;
        w_pc_nxt       = r_pc;
        w_inflight_nxt = w_issue;
        w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_rd_ptr_nxt   = r_rd_ptr;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_fault_nxt    = r_fault;
        if (Redirect_Valid) begin
            w_pc_nxt       = Redirect_Target & ~32'h3;
            w_inflight_nxt = 1'b0;
            w_count_nxt    = '0;
            w_rd_ptr_nxt   = '0;
            w_wr_ptr_nxt   = '0;
            w_fault_nxt    = 1'b0;
        end else begin
            if (w_issue) w_pc_nxt = r_pc + 32'd4;
            if (w_push)  w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
            if (w_pop)   w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
            if (w_try && w_oor) w_fault_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc       <= PC_RST;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_fault    <= 1'b0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else begin
            r_pc       <= w_pc_nxt;
            r_inflight <= w_inflight_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_fault    <= w_fault_nxt;
            if (w_issue) r_req_pc <= r_pc;
            if (w_push) begin
                r_q_instr[r_wr_ptr] <= Instr;
                r_q_pc[r_wr_ptr]    <= r_req_pc;
            end
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
        !(w_push && !w_pop && (32'(r_count) == QDEPTH)));

endmodule
